// File: rtl/mem_arbiter.sv
// Two-requester (CPU / data-break) arbiter for a single memory port.
// Grants DMA first but bounds how long a waiting CPU can be starved, and aborts stalled accesses.
module mem_arbiter #(
    parameter int AW           = 12,
    parameter int DW           = 12,
    parameter int STARVE_LIMIT = 3,
    parameter int TIMEOUT      = 255
) (
    input  logic          clock,
    input  logic          resetN,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,

    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_ack,
    output logic [DW-1:0] dma_rdata,

    output logic          mem_read_enable,
    output logic          mem_write_enable,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_write_data,
    input  logic [DW-1:0] mem_read_data,
    input  logic          mem_finished,

    output logic          owner,
    output logic          busy,
    output logic          err
);

    localparam int SC_W = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);
    localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        XFER    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DMA = 1'b1;

    state_t          state_q,     state_d;
    logic            owner_q,     owner_d;
    logic            we_q,        we_d;
    logic [AW-1:0]   addr_q,      addr_d;
    logic [DW-1:0]   wdata_q,     wdata_d;
    logic [SC_W-1:0] starve_q,    starve_d;
    logic [TO_W-1:0] tcnt_q,      tcnt_d;
    logic [DW-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0]   dma_rdata_q, dma_rdata_d;
    logic            cpu_ack_q,   cpu_ack_d;
    logic            dma_ack_q,   dma_ack_d;
    logic            err_q,       err_d;
    logic            rd_en_q,     rd_en_d;
    logic            wr_en_q,     wr_en_d;
    logic            busy_q,      busy_d;
    logic            grant_dma;

    always_comb begin
        // NOTE: every value written here gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        starve_d    = starve_q;
        tcnt_d      = tcnt_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        cpu_ack_d   = 1'b0;
        dma_ack_d   = 1'b0;
        err_d       = 1'b0;
        rd_en_d     = 1'b0;
        wr_en_d     = 1'b0;
        grant_dma   = 1'b0;

        case (state_q)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    // DMA wins unless the CPU has already been passed over STARVE_LIMIT times.
                    grant_dma = dma_req && (!cpu_req || (starve_q != STARVE_MAX));
                    state_d   = XFER;
                    tcnt_d    = '0;
                    if (grant_dma) begin
                        owner_d = OWNER_DMA;
                        we_d    = dma_we;
                        addr_d  = dma_addr;
                        wdata_d = dma_wdata;
                        if (!cpu_req) begin
                            starve_d = '0;
                        end else if (starve_q != STARVE_MAX) begin
                            starve_d = starve_q + SC_W'(1);
                        end
                    end else begin
                        owner_d  = OWNER_CPU;
                        we_d     = cpu_we;
                        addr_d   = cpu_addr;
                        wdata_d  = cpu_wdata;
                        starve_d = '0;
                    end
                    rd_en_d = !we_d;
                    wr_en_d = we_d;
                end
            end

            XFER: begin
                if (mem_finished || (tcnt_q == TO_LAST)) begin
                    state_d   = RELEASE;
                    cpu_ack_d = (owner_q == OWNER_CPU);
                    dma_ack_d = (owner_q == OWNER_DMA);
                    // Completion wins over timeout when both land on the last allowed cycle.
                    err_d     = !mem_finished;
                    if (mem_finished && !we_q) begin
                        if (owner_q == OWNER_DMA) begin
                            dma_rdata_d = mem_read_data;
                        end else begin
                            cpu_rdata_d = mem_read_data;
                        end
                    end
                end else begin
                    tcnt_d  = tcnt_q + TO_W'(1);
                    rd_en_d = !we_q;
                    wr_en_d = we_q;
                end
            end

            RELEASE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: the read-data registers are reset too, because their post-reset value of 0 is architecturally visible.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q     <= IDLE;
            owner_q     <= OWNER_CPU;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            starve_q    <= '0;
            tcnt_q      <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            err_q       <= 1'b0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            starve_q    <= starve_d;
            tcnt_q      <= tcnt_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_ack_q   <= dma_ack_d;
            err_q       <= err_d;
            rd_en_q     <= rd_en_d;
            wr_en_q     <= wr_en_d;
            busy_q      <= busy_d;
        end
    end

    assign cpu_ack          = cpu_ack_q;
    assign dma_ack          = dma_ack_q;
    assign cpu_rdata        = cpu_rdata_q;
    assign dma_rdata        = dma_rdata_q;
    assign mem_read_enable  = rd_en_q;
    assign mem_write_enable = wr_en_q;
    assign mem_address      = addr_q;
    assign mem_write_data   = wdata_q;
    assign owner            = owner_q;
    assign busy             = busy_q;
    assign err              = err_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, 12, address width in bits.
REQ-002 Parameter DW, 12, data width in bits.
REQ-003 Parameter STARVE_LIMIT, 3, maximum number of consecutive DMA grants while the CPU is waiting.
REQ-004 Parameter TIMEOUT, 255, maximum number of XFER cycles to wait for mem_finished before aborting.
REQ-005 Ports (name, direction, width, meaning):
- clock  in  1  system clock, rising edge.
- resetN  in  1  reset, asynchronous, active-low.
- cpu_req  in  1  CPU access request.
- cpu_we  in  1  CPU access is a write.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_ack  out  1  CPU access complete.
- cpu_rdata  out  DW  CPU read data.
- dma_req  in  1  data-break request.
- dma_we  in  1  data-break access is a write.
- dma_addr  in  AW  data-break address.
- dma_wdata  in  DW  data-break write data.
- dma_ack  out  1  data-break access complete.
- dma_rdata  out  DW  data-break read data.
- mem_read_enable  out  1  memory read strobe.
- mem_write_enable  out  1  memory write strobe.
- mem_address  out  AW  memory address.
- mem_write_data  out  DW  memory write data.
- mem_read_data  in  DW  memory read data.
- mem_finished  in  1  memory access complete.
- owner  out  1  current grant: 0 = CPU, 1 = DMA.
- busy  out  1  a transfer is in progress.
- err  out  1  the completing access timed out.

Function
REQ-006 The FSM SHALL have three states: IDLE, XFER, RELEASE.
REQ-007 IDLE transitions and grant priority:
- No request: remain in IDLE.
- Otherwise: go to XFER, choosing the grantee as follows.
- DMA only: grant DMA.
- CPU only: grant CPU.
- Both, starve_cnt < STARVE_LIMIT: grant DMA.
- Both, starve_cnt == STARVE_LIMIT: grant CPU.
REQ-008 At the grant edge the block SHALL latch the grantee's addr, we and wdata into internal registers, and SHALL set owner; later changes on the request inputs SHALL NOT affect the transfer.
REQ-009 starve_cnt update rules:
- DMA grant with cpu_req=1: increment, saturating at STARVE_LIMIT.
- DMA grant with cpu_req=0: clear.
- Any CPU grant: clear.
REQ-010 In XFER the block SHALL drive mem_address and mem_write_data from the latched registers, and assert exactly one strobe: mem_write_enable if latched we=1, else mem_read_enable.
REQ-011 In XFER with mem_finished=1, the block SHALL capture mem_read_data into the owner's rdata register (reads only) and go to RELEASE.
REQ-012 XFER SHALL count cycles; if the count reaches TIMEOUT without mem_finished, the block SHALL go to RELEASE with err set and leave rdata unchanged.
REQ-013 In RELEASE both strobes SHALL be 0. The owner's ack SHALL be 1 for exactly this one cycle, err SHALL be valid, and the next state SHALL be IDLE.
REQ-014 Requester obligations:
- A requester SHALL hold req, we, addr and wdata stable until it sees ack.
- It SHALL deassert req on the clock edge after ack.
- A req still high in IDLE is a new request.
REQ-015 Latency: req sampled in IDLE at cycle N gives strobes from N+1; mem_finished at cycle M gives ack at M+1 and IDLE at M+2. Minimum request-to-ack latency is 2 cycles, and the minimum spacing between grants is 3 cycles.
REQ-016 cpu_rdata and dma_rdata SHALL hold their values until the next successful read for that requester.
REQ-017 busy SHALL be 1 in XFER and RELEASE. mem_finished in IDLE or RELEASE SHALL be ignored.
REQ-018 The block SHALL never assert cpu_ack and dma_ack together, and SHALL never assert both strobes together.

Reset
REQ-019 While resetN=0, asynchronously:
- State SHALL be IDLE.
- Both strobes, both acks, err, busy and owner SHALL be 0.
- mem_address, mem_write_data, cpu_rdata and dma_rdata SHALL be 0.
- starve_cnt and the timeout count SHALL be 0.
REQ-020 Reset asserted during XFER SHALL drop the strobes immediately, produce no ack, and discard the transfer. After release of reset, pending requests SHALL be arbitrated afresh.

Verification
REQ-021 CPU read: cpu_req=1, cpu_addr=12'o0200, memory returns 12'o7402 with mem_finished on the 2nd XFER cycle -> mem_read_enable high for 2 cycles, cpu_ack one cycle later, cpu_rdata=12'o7402.
REQ-022 DMA write: dma_we=1, dma_addr=12'o0010, dma_wdata=12'o1234 -> mem_write_enable=1, mem_address=12'o0010, mem_write_data=12'o1234, dma_ack pulse, cpu_ack stays 0.
REQ-023 Simultaneous requests: cpu_req and dma_req held continuously, STARVE_LIMIT=3 -> grant order DMA, DMA, DMA, CPU, DMA, ...
REQ-024 Timeout: TIMEOUT=4, mem_finished held at 0 -> XFER lasts 4 cycles, then RELEASE with cpu_ack=1 and err=1; cpu_rdata is unchanged.
REQ-025 Reset mid-transfer: resetN low in the 1st XFER cycle -> strobes 0 in the same cycle, no ack; after release with cpu_req=1, a normal CPU transfer completes.
REQ-026 Stale completion: mem_finished pulsed during IDLE -> no ack and no state change.
